// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic            valid;
        logic            pred;
        logic [XLEN-1:0] fallthrough;
    } track_entry_t;

endpackage

// File: rtl/branch_track_pipe.sv
// Shift register carrying predicted-branch records from decode down to MEM.
module branch_track_pipe
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         clear,
    input  logic         tail_inv,
    input  track_entry_t entry_in,
    output track_entry_t tail
);

    track_entry_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            // A resolved tail shifts out here, so tail_inv needs no action.
            stage[0] <= entry_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end else if (tail_inv) begin
            stage[DEPTH-1].valid <= 1'b0;
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: predicted redirect, MEM-stage mispredict recovery, statistics.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PIPE_DEPTH = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_decode_sig,
    input  logic             prediction,
    input  logic [31:0]      branch_addr,
    input  logic [31:0]      decode_pc,
    input  logic             branch_mem_sig,
    input  logic             actual_branch_decision,
    input  logic [31:0]      actual_target,
    output logic [31:0]      pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             track_err
);

    track_entry_t dec_entry;
    track_entry_t tail;
    logic         mispredict;
    logic [31:0]  pc_next;

    assign dec_entry.valid       = branch_decode_sig;
    assign dec_entry.pred        = prediction;
    assign dec_entry.fallthrough = decode_pc + INSTR_BYTES;

    branch_track_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_track (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .clear    (mispredict),
        .tail_inv (branch_mem_sig),
        .entry_in (dec_entry),
        .tail     (tail)
    );

    assign mispredict = branch_mem_sig & tail.valid & (tail.pred != actual_branch_decision);
    assign flush      = mispredict;

    always_comb begin
        pc_next = pc + INSTR_BYTES;
        if (mispredict) begin
            pc_next = actual_branch_decision ? actual_target : tail.fallthrough;
        end else if (stall) begin
            pc_next = pc;
        end else if (branch_decode_sig && prediction) begin
            pc_next = branch_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Statistics saturate rather than wrap so the debug readout never looks small.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
            track_err        <= 1'b0;
        end else begin
            if (branch_mem_sig && (branch_count != '1)) begin
                branch_count <= branch_count + 1'b1;
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
            if (branch_mem_sig && !tail.valid) begin
                track_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a list-of-in-flight-branches reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          D      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_decode_sig;
    logic        prediction;
    logic [31:0] branch_addr;
    logic [31:0] decode_pc;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [31:0] actual_target;

    logic [31:0] pc,   pc_s;
    logic        flush, flush_s;
    logic [15:0] branch_count, mispredict_count;
    logic [1:0]  bc_s, mc_s;
    logic        track_err, te_s;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC), .PIPE_DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_decode_sig(branch_decode_sig), .prediction(prediction),
        .branch_addr(branch_addr), .decode_pc(decode_pc),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .actual_target(actual_target),
        .pc(pc), .flush(flush), .branch_count(branch_count),
        .mispredict_count(mispredict_count), .track_err(track_err)
    );

    // Narrow-counter copy to reach saturation in a few transactions.
    fetch_pc_unit #(.RESET_PC(RST_PC), .PIPE_DEPTH(D), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_decode_sig(branch_decode_sig), .prediction(prediction),
        .branch_addr(branch_addr), .decode_pc(decode_pc),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .actual_target(actual_target),
        .pc(pc_s), .flush(flush_s), .branch_count(bc_s),
        .mispredict_count(mc_s), .track_err(te_s)
    );

    typedef struct {
        int          age;
        bit          pred;
        logic [31:0] ft;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_pc, m_bc, m_mc, m_bcs, m_mcs;
    logic        m_te;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v, input logic [31:0] mx);
        return (v == mx) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = RST_PC; m_bc = 0; m_mc = 0; m_bcs = 0; m_mcs = 0; m_te = 1'b0;
    endtask

    // One clock: compare at negedge against model, advance model, return at posedge+1.
    task automatic step();
        int   ti;
        bit   tail_ok, mis;
        rec_t nq[$];
        @(negedge clk);
        ti = -1;
        foreach (q[i]) if (q[i].age == D) ti = i;
        tail_ok = (ti >= 0);
        mis = branch_mem_sig && tail_ok && (q[ti].pred != actual_branch_decision);
        chk("pc", pc, m_pc);
        chk("flush", {31'd0, flush}, {31'd0, mis});
        chk("branch_count", {16'd0, branch_count}, m_bc);
        chk("mispredict_count", {16'd0, mispredict_count}, m_mc);
        chk("track_err", {31'd0, track_err}, {31'd0, m_te});
        chk("sat_branch_count", {30'd0, bc_s}, m_bcs);
        chk("sat_mispredict_count", {30'd0, mc_s}, m_mcs);
        if (!rst) begin
            if (branch_mem_sig) begin
                m_bc  = sat(m_bc, 32'hFFFF);
                m_bcs = sat(m_bcs, 32'd3);
                if (!tail_ok) m_te = 1'b1;
            end
            if (mis) begin
                m_mc  = sat(m_mc, 32'hFFFF);
                m_mcs = sat(m_mcs, 32'd3);
                m_pc  = actual_branch_decision ? actual_target : q[ti].ft;
                q.delete();
            end else begin
                if (branch_mem_sig && tail_ok) q.delete(ti);
                if (!stall) begin
                    foreach (q[i]) if (q[i].age < D) nq.push_back('{q[i].age + 1, q[i].pred, q[i].ft});
                    if (branch_decode_sig) nq.push_back('{1, prediction, decode_pc + 32'd4});
                    q = nq;
                end
                if (!stall) m_pc = (branch_decode_sig && prediction) ? branch_addr : m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; branch_decode_sig = 0; prediction = 0; branch_addr = 0; decode_pc = 0;
        branch_mem_sig = 0; actual_branch_decision = 0; actual_target = 0;
    endtask

    task automatic decode(input logic [31:0] dpc, input logic pr, input logic [31:0] tgt);
        branch_decode_sig = 1; decode_pc = dpc; prediction = pr; branch_addr = tgt;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        branch_mem_sig = 1; actual_branch_decision = taken; actual_target = tgt;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        step(); step();
        rst = 0;

        // free-running sequence from reset
        chk("t1_pc0", pc, 32'h100);
        repeat (4) step();
        chk("t1_pc4", pc, 32'h110);
        chk("t1_bc", {16'd0, branch_count}, 32'd0);

        // predicted taken, resolved taken
        decode(32'h200, 1, 32'h240); step();
        idle_inputs();
        chk("t2_redirect", pc, 32'h240);
        step();
        resolve(1, 32'h240); #1;
        chk("t2_flush", {31'd0, flush}, 32'd0);
        step(); idle_inputs();
        chk("t2_bc", {16'd0, branch_count}, 32'd1);
        chk("t2_mc", {16'd0, mispredict_count}, 32'd0);

        // predicted taken, resolved not-taken
        decode(32'h200, 1, 32'h240); step(); idle_inputs(); step();
        resolve(0, 32'h0); #1;
        chk("t3_flush", {31'd0, flush}, 32'd1);
        step(); idle_inputs();
        chk("t3_pc", pc, 32'h204);
        chk("t3_flush_low", {31'd0, flush}, 32'd0);
        chk("t3_mc", {16'd0, mispredict_count}, 32'd1);

        // predicted not-taken, resolved taken under stall with a competing decode
        decode(32'h300, 0, 32'h340); step(); idle_inputs(); step();
        resolve(1, 32'h380); stall = 1; decode(32'h999, 1, 32'h990); #1;
        chk("t4_flush", {31'd0, flush}, 32'd1);
        step(); idle_inputs();
        chk("t4_pc", pc, 32'h380);
        step(); step();
        resolve(0, 32'h0); #1;
        chk("t5_no_flush", {31'd0, flush}, 32'd0);
        step(); idle_inputs();
        chk("t5_track_err", {31'd0, track_err}, 32'd1);
        chk("t5_pc", pc, 32'h38C);

        // stall delays resolution by one edge
        decode(32'h400, 1, 32'h500); step(); idle_inputs();
        stall = 1; step(); stall = 0;
        chk("t6_hold", pc, 32'h500);
        step();
        resolve(0, 32'h0); #1;
        chk("t6_flush", {31'd0, flush}, 32'd1);
        step(); idle_inputs();
        chk("t6_pc", pc, 32'h404);

        // PC wrap
        decode(32'h410, 1, 32'hFFFF_FFFC); step(); idle_inputs();
        chk("t7_pc_top", pc, 32'hFFFF_FFFC);
        step();
        chk("t7_wrap", pc, 32'h0);
        resolve(1, 32'hFFFF_FFFC); step(); idle_inputs();

        // saturation of narrow counters
        for (int k = 0; k < 4; k++) begin
            decode(32'h600, 0, 32'h0); step(); idle_inputs(); step();
            resolve(1, 32'h700); step(); idle_inputs();
        end
        chk("t8_sat_mc", {30'd0, mc_s}, 32'd3);
        chk("t8_sat_bc", {30'd0, bc_s}, 32'd3);
        chk("t8_pc", pc, 32'h700);

        // reset while a branch is in flight
        decode(32'h800, 1, 32'h900); step(); idle_inputs();
        rst = 1; model_reset(); #1;
        chk("t9_rst_pc", pc, RST_PC);
        step();
        rst = 0;
        step();
        resolve(0, 32'h0); #1;
        chk("t9_no_flush", {31'd0, flush}, 32'd0);
        chk("t9_te_clear", {31'd0, track_err}, 32'd0);
        step(); idle_inputs();
        chk("t9_te_set", {31'd0, track_err}, 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
